// File: rtl/param_updown_counter.sv
// Purpose: parameterised up/down counter with clamped load, terminal-count pulse and sticky wrap flag.
// Latency: 1 cycle from load/en to data_out, tc and wrap_flag; zero is combinational from the count.
// Backpressure: none, a new command is accepted every cycle. Boundary mode: wrap by default, saturate when CNT_SATURATE_EN is defined.
module param_updown_counter #(
  parameter int               WIDTH   = 16,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic             mode,
  input  logic [WIDTH-1:0] data_in,
  input  logic             clr_flag,
  output logic [WIDTH-1:0] data_out,
  output logic             tc,
  output logic             wrap_flag,
  output logic             zero
);

`ifdef CNT_SATURATE_EN
  localparam bit SATURATE = 1'b1;
`else
  localparam bit SATURATE = 1'b0;
`endif

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             flag_q, flag_d;
  logic             at_top;
  logic             at_bottom;
  logic             boundary;

  assign at_top    = (cnt_q == MAX_VAL);
  assign at_bottom = (cnt_q == '0);
  // A boundary event only exists in a counting cycle; load pre-empts it.
  assign boundary  = en && !load && (mode ? at_top : at_bottom);

  // Next-state selection: load beats count, out-of-range loads clamp to MAX_VAL.
  always_comb begin
    cnt_d  = cnt_q;
    tc_d   = 1'b0;
    flag_d = flag_q;
    if (load) begin
      cnt_d = (data_in > MAX_VAL) ? MAX_VAL : data_in;
    end else if (en) begin
      if (mode) begin
        if (at_top) cnt_d = SATURATE ? MAX_VAL : '0;
        else        cnt_d = cnt_q + 1'b1;
      end else begin
        if (at_bottom) cnt_d = SATURATE ? '0 : MAX_VAL;
        else           cnt_d = cnt_q - 1'b1;
      end
    end
    tc_d = boundary;
    // Setting the flag wins over a simultaneous clear.
    if (boundary)      flag_d = 1'b1;
    else if (clr_flag) flag_d = 1'b0;
  end

  // State registers with synchronous reset overriding every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      tc_q   <= 1'b0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tc_q   <= tc_d;
      flag_q <= flag_d;
    end
  end

  assign data_out  = cnt_q;
  assign tc        = tc_q;
  assign wrap_flag = flag_q;
  // Forced high while reset is held so zero is valid before the first reset edge.
  assign zero      = reset || at_bottom;

endmodule

// File: tb/tb_param_updown_counter.sv
// Bench for param_updown_counter (WIDTH=16, MAX_VAL=9): directed boundary cases, then random traffic.
// Expected values come from an arithmetic model of the counting rules.
// Build with CNT_SATURATE_EN defined to check the saturating variant.
module tb_param_updown_counter;
  localparam int WIDTH = 16;
  localparam int MAXV  = 9;
`ifdef CNT_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset, en, load, mode, clr_flag;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             tc, wrap_flag, zero;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  int m_cnt  = 0;
  int m_tc   = 0;
  int m_flag = 0;

  param_updown_counter #(.WIDTH(WIDTH), .MAX_VAL(16'(MAXV))) dut (
    .clk(clk), .reset(reset), .en(en), .load(load), .mode(mode),
    .data_in(data_in), .clr_flag(clr_flag),
    .data_out(data_out), .tc(tc), .wrap_flag(wrap_flag), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: next count from the rules in plain arithmetic modulo the range size.
  task automatic model(input bit r, input bit l, input bit e, input bit m,
                       input int d, input bit c);
    bit bnd;
    if (r) begin
      m_cnt = 0; m_tc = 0; m_flag = 0;
    end else if (l) begin
      m_cnt = (d > MAXV) ? MAXV : d;
      m_tc  = 0;
      if (c) m_flag = 0;
    end else if (e) begin
      bnd = m ? (m_cnt == MAXV) : (m_cnt == 0);
      if (m) m_cnt = SAT ? ((m_cnt + 1 > MAXV) ? MAXV : m_cnt + 1) : (m_cnt + 1) % (MAXV + 1);
      else   m_cnt = SAT ? ((m_cnt - 1 < 0) ? 0 : m_cnt - 1)      : (m_cnt + MAXV) % (MAXV + 1);
      m_tc = bnd ? 1 : 0;
      if (bnd)    m_flag = 1;
      else if (c) m_flag = 0;
    end else begin
      m_tc = 0;
      if (c) m_flag = 0;
    end
  endtask

  // Drive one cycle of inputs, clock it, then compare every output with the model.
  task automatic step(input bit r, input bit l, input bit e, input bit m,
                      input int d, input bit c);
    reset = r; load = l; en = e; mode = m; data_in = 16'(d); clr_flag = c;
    @(posedge clk);
    model(r, l, e, m, d, c);
    #1;
    chk("data_out",  32'(data_out),  32'(m_cnt));
    chk("tc",        32'(tc),        32'(m_tc));
    chk("wrap_flag", 32'(wrap_flag), 32'(m_flag));
    chk("zero",      32'(zero),      32'((r || m_cnt == 0) ? 1 : 0));
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; en = 1'b0; mode = 1'b0; data_in = '0; clr_flag = 1'b0;
    #1;
    chk("zero_in_reset", 32'(zero), 32'd1);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 1, 0, 1);

    // Count to 5, then reset while loading 9
    for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 0, 0);
    chk("count_to_5", 32'(data_out), 32'd5);
    step(1, 1, 1, 1, 9, 0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_tc",   32'(tc),       32'd0);
    chk("rst_flag", 32'(wrap_flag),32'd0);
    chk("rst_zero", 32'(zero),     32'd1);
    // First count after reset on the first edge with reset low
    step(0, 0, 1, 1, 0, 0);
    chk("first_count", 32'(data_out), 32'd1);

    // Load clamp
    step(0, 1, 0, 0, 20, 0);
    chk("clamp_data", 32'(data_out), 32'd9);
    chk("clamp_tc",   32'(tc),       32'd0);

    // Up boundary
    step(0, 1, 0, 0, 7, 0);
    step(0, 0, 1, 1, 0, 0);
    chk("up_8", 32'(data_out), 32'd8);
    step(0, 0, 1, 1, 0, 0);
    chk("up_9", 32'(data_out), 32'd9);
    step(0, 0, 1, 1, 0, 0);
    chk("up_bnd_data", 32'(data_out), SAT ? 32'd9 : 32'd0);
    chk("up_bnd_tc",   32'(tc),       32'd1);
    chk("up_bnd_flag", 32'(wrap_flag),32'd1);
    step(0, 0, 0, 1, 0, 0);
    chk("tc_one_cycle", 32'(tc), 32'd0);
    chk("flag_sticky",  32'(wrap_flag), 32'd1);

    // Down boundary
    step(0, 1, 0, 0, 1, 1);
    step(0, 0, 1, 0, 0, 0);
    chk("dn_0",    32'(data_out), 32'd0);
    chk("dn_0_tc", 32'(tc),       32'd0);
    step(0, 0, 1, 0, 0, 0);
    chk("dn_bnd_data", 32'(data_out), SAT ? 32'd0 : 32'd9);
    chk("dn_bnd_tc",   32'(tc),       32'd1);

    // Clear/set race then clear alone
    step(0, 1, 0, 0, 9, 0);
    step(0, 0, 1, 1, 0, 1);
    chk("race_flag", 32'(wrap_flag), 32'd1);
    step(0, 0, 0, 0, 0, 1);
    chk("clr_flag", 32'(wrap_flag), 32'd0);

    // Load beats enable
    step(0, 1, 1, 1, 3, 0);
    chk("prio_load", 32'(data_out), 32'd3);
    step(0, 0, 1, 1, 0, 0);
    chk("prio_then_en", 32'(data_out), 32'd4);

    // Random traffic with mode toggling freely
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 50) == 0, ($urandom % 8) == 0, ($urandom % 4) != 0,
           $urandom % 2, int'($urandom % 16), ($urandom % 6) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/param_updown_counter.md
PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 16, counter and data width in bits (2..32).
REQ-002 SHALL have parameter MAX_VAL, default 2**WIDTH-1, top of count range (range 0..MAX_VAL, 1 <= MAX_VAL <= 2**WIDTH-1).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous active-high reset.
REQ-005 SHALL have port en  input  1  count enable.
REQ-006 SHALL have port load  input  1  parallel load strobe.
REQ-007 SHALL have port mode  input  1  direction, 1 = up, 0 = down.
REQ-008 SHALL have port data_in  input  WIDTH  load value.
REQ-009 SHALL have port clr_flag  input  1  clears sticky wrap_flag.
REQ-010 SHALL have port data_out  output  WIDTH  registered count.
REQ-011 SHALL have port tc  output  1  registered terminal-count pulse.
REQ-012 SHALL have port wrap_flag  output  1  sticky boundary-crossing flag.
REQ-013 SHALL have port zero  output  1  combinational, high when data_out == 0.

Function
REQ-014 SHALL evaluate per edge with priority reset > load > en; no change when none is asserted.
REQ-015 SHALL, on load, set data_out to data_in in the next cycle; if data_in > MAX_VAL, load MAX_VAL instead.
REQ-016 SHALL ignore en and mode in a load cycle; tc SHALL be 0 in the cycle after a load.
REQ-017 SHALL, with en and mode=1 and data_out < MAX_VAL, increment by 1 (latency 1 cycle).
REQ-018 SHALL, with en and mode=0 and data_out > 0, decrement by 1 (latency 1 cycle).
REQ-019 SHALL treat count up at MAX_VAL and count down at 0 as a boundary event; the next value is defined by REQ-030/031.
REQ-020 SHALL assert tc for exactly one cycle, coincident with the post-boundary data_out value; consecutive boundary events give consecutive tc pulses.
REQ-021 SHALL set wrap_flag on every boundary event and hold it until clr_flag is applied.
REQ-022 SHALL, when clr_flag and a boundary event coincide, leave wrap_flag = 1 (set wins).
REQ-023 SHALL allow mode to change every cycle with no dead cycle.
REQ-024 SHALL keep all arithmetic in WIDTH bits; no intermediate result may exceed MAX_VAL on data_out.

Reset
REQ-025 SHALL, on reset high at a rising edge, set data_out=0, tc=0 and wrap_flag=0, regardless of load, en and clr_flag.
REQ-026 SHALL abort any in-progress count on reset; the first count occurs on the first edge with reset low and en high.
REQ-027 SHALL drive zero=1 throughout reset.

Configuration
REQ-028 SHALL use macro CNT_SATURATE_EN to select boundary behaviour.
REQ-029 SHALL apply the same boundary behaviour for every MAX_VAL.
REQ-030 SHALL, with CNT_SATURATE_EN undefined, wrap: up from MAX_VAL goes to 0, down from 0 goes to MAX_VAL.
REQ-031 SHALL, with CNT_SATURATE_EN defined, saturate: data_out holds at MAX_VAL (up) or 0 (down), while tc and wrap_flag still assert per REQ-020/021.

Verification
REQ-032 SHALL cover reset: WIDTH=16, count to 5, assert reset with load=1 and data_in=9 -> data_out=0, tc=0, wrap_flag=0, zero=1.
REQ-033 SHALL cover load clamp: MAX_VAL=9, load data_in=20 -> data_out=9 next cycle, tc=0.
REQ-034 SHALL cover up boundary: MAX_VAL=9, count 8,9 then one more up -> data_out=0 (wrap build) or 9 (CNT_SATURATE_EN), tc pulse 1 cycle, wrap_flag=1.
REQ-035 SHALL cover down boundary: load 1, en, mode=0 for 2 cycles -> 0 then 9 (wrap) or 0 (saturate), tc=1 on second cycle.
REQ-036 SHALL cover flag race: clr_flag high in the same cycle as a boundary event -> wrap_flag remains 1; clr_flag alone next cycle -> wrap_flag=0.
REQ-037 SHALL cover priority: load=1, en=1, mode=1, data_in=3 -> data_out=3 (not 4), then en alone -> 4.
